// File: rtl/data_sram_resp_pkg.sv
// Shared constants and helpers for the data SRAM responder.
package data_sram_resp_pkg;

  // MMIO register offsets within the 64 KiB window (word aligned).
  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_NUM     = 16'h0004;
  localparam logic [15:0] OFF_TIMER   = 16'he000;
  localparam logic [15:0] OFF_SCRATCH = 16'hf000;

  // Replace the bytes of old_word selected by mask with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_resp_bram_be.sv
// Single-port byte-writable RAM with a registered read port.
module bram_be #(
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk_i,
  input  logic                 en_i,
  input  logic [3:0]           we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [0:(2**AddrWidth)-1];
  logic [31:0] rdata_q;

  // Per-lane write; the read register only loads on read requests so it holds across writes.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i == 4'b0000) begin
        rdata_q <= mem_q[addr_i];
      end
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM responder: decodes requests to RAM or the MMIO window, 1-cycle read latency.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num
);

  logic        req, is_wr, mmio_hit, mmio_wr, mmio_rd;
  logic [15:0] off;
  logic [31:0] ram_rdata, mmio_rval;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] mmio_rd_q;
  logic        sel_mmio_q;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = data_sram_addr[1:0];

  // A request in the reset cycle is ignored entirely, RAM included.
  assign req      = data_sram_en && !reset;
  assign is_wr    = |data_sram_we;
  assign mmio_hit = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off      = {data_sram_addr[15:2], 2'b00};
  assign mmio_wr  = req && mmio_hit && is_wr;
  assign mmio_rd  = req && mmio_hit && !is_wr;

  bram_be #(
    .AddrWidth (ADDR_WIDTH)
  ) u_bram (
    .clk_i   (clk),
    .en_i    (req && !mmio_hit),
    .we_i    (data_sram_we),
    .addr_i  (data_sram_addr[ADDR_WIDTH+1:2]),
    .wdata_i (data_sram_wdata),
    .rdata_o (ram_rdata)
  );

  // MMIO register next-state; the timer free-runs unless written this cycle.
  always_comb begin
    led_d     = led_q;
    num_d     = num_q;
    scratch_d = scratch_q;
    timer_d   = timer_q + 32'd1;
    if (mmio_wr) begin
      unique case (off)
        OFF_LED: begin
          if (data_sram_we[0]) led_d[7:0]  = data_sram_wdata[7:0];
          if (data_sram_we[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        OFF_NUM:     num_d     = merge_bytes(num_q, data_sram_wdata, data_sram_we);
        OFF_TIMER:   timer_d   = merge_bytes(timer_q, data_sram_wdata, data_sram_we);
        OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_we);
        default: ;
      endcase
    end
  end

  // MMIO read value from the pre-edge register contents.
  always_comb begin
    mmio_rval = 32'h0;
    unique case (off)
      OFF_LED:     mmio_rval = {16'h0, led_q};
      OFF_NUM:     mmio_rval = num_q;
      OFF_TIMER:   mmio_rval = timer_q;
      OFF_SCRATCH: mmio_rval = scratch_q;
      default:     mmio_rval = 32'h0;
    endcase
  end

  // State update; reset selects the cleared MMIO read register so rdata reads 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= 16'h0;
      num_q      <= 32'h0;
      timer_q    <= 32'h0;
      scratch_q  <= 32'h0;
      mmio_rd_q  <= 32'h0;
      sel_mmio_q <= 1'b1;
    end else begin
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      scratch_q <= scratch_d;
      if (mmio_rd) mmio_rd_q <= mmio_rval;
      if (req && !is_wr) sel_mmio_q <= mmio_hit;
    end
  end

  assign data_sram_rdata = sel_mmio_q ? mmio_rd_q : ram_rdata;
  assign led             = led_q;
  assign num             = num_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] num;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  localparam logic [31:0] A_LED     = 32'hbfaf_0000;
  localparam logic [31:0] A_NUM     = 32'hbfaf_0004;
  localparam logic [31:0] A_HOLE    = 32'hbfaf_0100;
  localparam logic [31:0] A_TIMER   = 32'hbfaf_e000;
  localparam logic [31:0] A_SCRATCH = 32'hbfaf_f000;

  always #5 clk = ~clk;

  data_sram_resp #(
    .ADDR_WIDTH (12),
    .MMIO_BASE  (32'hbfaf_0000)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .num             (num)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present one request for one clock edge, then sample 1 time unit after the edge.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d);
    en    = e;
    we    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    en = 1'b0;
    we = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    we    = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num, 32'h0);

    // Timer counts from 0 after the last reset edge; third cycle read sees 2.
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_after_reset", rdata, 32'h2);

    // RAM byte-lane writes; rdata holds across writes.
    cyc(1'b1, 4'hf, 32'h0000_0010, 32'h1234_5678);
    check("rdata_hold_wr", rdata, 32'h2);
    cyc(1'b1, 4'b0100, 32'h0000_0010, 32'h00aa_0000);
    cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_lane_merge", rdata, 32'h12aa_5678);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    check("rdata_hold_idle", rdata, 32'h12aa_5678);

    // Alias and back-to-back reads.
    cyc(1'b1, 4'hf, 32'h0000_0014, 32'hcafe_f00d);
    cyc(1'b1, 4'h0, 32'h0000_4014, 32'h0);
    check("ram_alias", rdata, 32'hcafe_f00d);
    cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("b2b_rd0", rdata, 32'h12aa_5678);
    cyc(1'b1, 4'h0, 32'h0000_0014, 32'h0);
    check("b2b_rd1", rdata, 32'hcafe_f00d);
    cyc(1'b1, 4'h0, 32'h0000_4010, 32'h0);
    check("ram_alias2", rdata, 32'h12aa_5678);

    // Write then read same address on consecutive cycles.
    cyc(1'b1, 4'hf, 32'h0000_0020, 32'h1122_3344);
    cyc(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("wr_then_rd", rdata, 32'h1122_3344);

    // MMIO registers.
    cyc(1'b1, 4'hf, A_LED, 32'hdead_beef);
    check("led_write", {16'h0, led}, 32'h0000_beef);
    cyc(1'b1, 4'hf, A_NUM, 32'h0000_0007);
    check("num_write", num, 32'h7);
    cyc(1'b1, 4'hf, A_HOLE, 32'hffff_ffff);
    cyc(1'b1, 4'h0, A_HOLE, 32'h0);
    check("mmio_hole_rd", rdata, 32'h0);
    cyc(1'b1, 4'h0, A_LED, 32'h0);
    check("led_readback", rdata, 32'h0000_beef);
    cyc(1'b1, 4'b0010, A_NUM, 32'h0000_5500);
    cyc(1'b1, 4'h0, A_NUM, 32'h0);
    check("num_lane1", rdata, 32'h0000_5507);
    cyc(1'b1, 4'hf, A_SCRATCH, 32'ha5a5_a5a5);
    cyc(1'b1, 4'b0011, A_SCRATCH, 32'hffff_1234);
    cyc(1'b1, 4'h0, A_SCRATCH, 32'h0);
    check("scratch_lanes", rdata, 32'ha5a5_1234);
    cyc(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    check("ram_after_mmio", rdata, 32'h1122_3344);

    // Timer load and resume counting.
    cyc(1'b1, 4'hf, A_TIMER, 32'h0000_0100);
    cyc(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_load", rdata, 32'h100);
    cyc(1'b1, 4'h0, A_TIMER, 32'h0);
    check("timer_inc", rdata, 32'h101);

    // Reset with a read in flight; a write in the reset cycle must be dropped.
    cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("pre_reset_rd", rdata, 32'h12aa_5678);
    reset = 1'b1;
    cyc(1'b1, 4'hf, 32'h0000_0010, 32'h0);
    reset = 1'b0;
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num, 32'h0);
    cyc(1'b1, 4'h0, A_TIMER, 32'h0);
    check("rst_timer", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("ram_survives_rst", rdata, 32'h12aa_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
